// File: rtl/pkt_assembler_crc8_if.sv
// Bus bundle for the packet-build stage: control, read burst, write burst and status.
// The slave modport is the assembler's own view; master is the surrounding system.
interface pkt_assembler_crc8_if;
    logic        start;
    logic [3:0]  byte_cnt;
    logic [3:0]  data_sel;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, byte_cnt, data_sel, rdata, rvalid, rlast, wready,
        input  rready, wdata, wvalid, wlast, busy, done, err
    );

    modport slave (
        input  start, byte_cnt, data_sel, rdata, rvalid, rlast, wready,
        output rready, wdata, wvalid, wlast, busy, done, err
    );
endinterface

// File: rtl/pkt_assembler_crc8.sv
// Packet-build stage: gathers payload bytes from one read burst, frames them with a
// 2-byte header and trailing CRC8, and streams the packet out as one write burst.
module pkt_assembler_crc8 #(
    parameter logic [7:0] HDR_MARK = 8'hA5,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    pkt_assembler_crc8_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // 32 bytes so any 3-bit word index stays inside the array; only 0..19 ever hold data.
    localparam int BUF_BYTES = 32;

    logic [1:0]  r_state;
    logic [3:0]  r_data_sel;
    logic [4:0]  r_beats_left;
    logic [4:0]  r_bytes_left;
    logic [4:0]  r_wr_ptr;
    logic [7:0]  r_crc;
    logic [7:0]  r_buf [BUF_BYTES];
    logic [2:0]  r_wbeat;
    logic [4:0]  r_wlast_idx;
    logic [31:0] r_wdata;
    logic        r_wvalid;
    logic        r_wlast;
    logic        r_err;

    logic [4:0]  w_n;
    logic [4:0]  w_rbeats;
    logic [7:0]  w_hdr_crc;
    logic [2:0]  w_lanes;
    logic [2:0]  w_take;
    logic [7:0]  w_crc_next;
    logic        w_accept;
    logic        w_final_beat;
    logic [2:0]  w_word_idx;
    logic [31:0] w_word;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign w_n       = {1'b0, bus.byte_cnt} + 5'd1;
    assign w_hdr_crc = crc8_byte(crc8_byte(CRC_INIT, {bus.data_sel, bus.byte_cnt}), HDR_MARK);

    always_comb begin
        w_rbeats = 5'd0;
        case (bus.data_sel)
            4'd0:    w_rbeats = w_n;
            4'd1:    w_rbeats = (w_n + 5'd1) >> 1;
            4'd2:    w_rbeats = (w_n + 5'd3) >> 2;
            default: w_rbeats = 5'd0;
        endcase
    end

    always_comb begin
        w_lanes = 3'd4;
        case (r_data_sel)
            4'd0:    w_lanes = 3'd1;
            4'd1:    w_lanes = 3'd2;
            default: w_lanes = 3'd4;
        endcase
    end

    // The last beat of a burst may carry fewer payload bytes than it has lanes.
    assign w_take       = ({2'b00, w_lanes} > r_bytes_left) ? r_bytes_left[2:0] : w_lanes;
    assign w_accept     = (r_state == S_READ) && bus.rvalid;
    assign w_final_beat = (r_beats_left == 5'd1);

    always_comb begin
        w_crc_next = r_crc;
        for (int l = 0; l < 4; l++) begin
            if (3'(l) < w_take) begin
                w_crc_next = crc8_byte(w_crc_next, bus.rdata[8*l +: 8]);
            end
        end
    end

    assign w_word_idx = r_wvalid ? (r_wbeat + 3'd1) : 3'd0;
    assign w_word     = {r_buf[{w_word_idx, 2'd3}], r_buf[{w_word_idx, 2'd2}],
                         r_buf[{w_word_idx, 2'd1}], r_buf[{w_word_idx, 2'd0}]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_data_sel   <= 4'd0;
            r_beats_left <= 5'd0;
            r_bytes_left <= 5'd0;
            r_wr_ptr     <= 5'd0;
            r_crc        <= CRC_INIT;
            r_wbeat      <= 3'd0;
            r_wlast_idx  <= 5'd0;
            r_wdata      <= 32'd0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_err        <= 1'b0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                r_buf[i] <= 8'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < BUF_BYTES; i++) begin
                            r_buf[i] <= 8'd0;
                        end
                        r_buf[0]     <= {bus.data_sel, bus.byte_cnt};
                        r_buf[1]     <= HDR_MARK;
                        r_data_sel   <= bus.data_sel;
                        r_crc        <= w_hdr_crc;
                        r_wr_ptr     <= 5'd2;
                        r_bytes_left <= w_n;
                        r_beats_left <= w_rbeats;
                        r_wlast_idx  <= (w_n + 5'd2) >> 2;
                        r_wbeat      <= 3'd0;
                        if (bus.data_sel > 4'd2) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_accept) begin
                        for (int l = 0; l < 4; l++) begin
                            if (3'(l) < w_take) begin
                                r_buf[r_wr_ptr + 5'(l)] <= bus.rdata[8*l +: 8];
                            end
                        end
                        r_crc        <= w_crc_next;
                        r_wr_ptr     <= r_wr_ptr + {2'b00, w_take};
                        r_bytes_left <= r_bytes_left - {2'b00, w_take};
                        r_beats_left <= r_beats_left - 5'd1;
                        if (w_final_beat && bus.rlast) begin
                            r_buf[r_wr_ptr + {2'b00, w_take}] <= w_crc_next;
                            r_state <= S_WRITE;
                        end else if (w_final_beat || bus.rlast) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    // wvalid low inside WRITE only on the entry cycle, when word 0 is loaded.
                    if (!r_wvalid) begin
                        r_wvalid <= 1'b1;
                        r_wbeat  <= 3'd0;
                        r_wdata  <= w_word;
                        r_wlast  <= (r_wlast_idx == 5'd0);
                    end else if (bus.wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_wbeat <= r_wbeat + 3'd1;
                            r_wdata <= w_word;
                            r_wlast <= (({2'b00, r_wbeat} + 5'd1) == r_wlast_idx);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rready = (r_state == S_READ);
    assign bus.wdata  = r_wdata;
    assign bus.wvalid = r_wvalid;
    assign bus.wlast  = r_wlast;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.err    = r_err;
endmodule
